// File: rtl/lmem_decode_sequencer.sv
// Lmem sequencer for one LDPC codeword decode: load rows, run layered
// read/write passes with a fixed RCU latency, then unload hard decisions.
module lmem_decode_sequencer #(
  parameter int ROWDEPTH     = 20,
  parameter int ADDRESSWIDTH = 5,
  parameter int LAYERS       = 2,
  parameter int PIPESTAGES   = 15,
  parameter int MAXITRS      = 10,
  parameter int ITRWIDTH     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    early_stop,
  output logic                    loaden,
  output logic [ADDRESSWIDTH-1:0] load_addr,
  output logic                    rd_en,
  output logic [ADDRESSWIDTH-1:0] rd_address,
  output logic                    rd_layer,
  output logic                    wr_en,
  output logic [ADDRESSWIDTH-1:0] wr_address,
  output logic                    wr_layer,
  output logic                    firstprocessing_indicate,
  output logic                    unload_en,
  output logic [ADDRESSWIDTH-1:0] unloadAddress,
  output logic [ITRWIDTH-1:0]     itr,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_READ, S_WAIT, S_UNLOAD, S_DONE
  } state_t;

  typedef struct packed {
    logic                    valid;
    logic [ADDRESSWIDTH-1:0] addr;
    logic                    layer;
  } wr_slot_t;

  localparam logic [ADDRESSWIDTH-1:0] ROW_LAST   = ADDRESSWIDTH'(ROWDEPTH - 1);
  localparam logic [ADDRESSWIDTH-1:0] ROW_ONE    = ADDRESSWIDTH'(1);
  localparam logic [ITRWIDTH-1:0]     ITR_LAST   = ITRWIDTH'(MAXITRS - 1);
  localparam logic [ITRWIDTH-1:0]     ITR_ONE    = ITRWIDTH'(1);
  localparam logic                    LAYER_LAST = 1'(LAYERS - 1);

  state_t                  state, state_next;
  logic [ADDRESSWIDTH-1:0] row, row_next, row_inc;
  logic                    layer, layer_next;
  logic [ITRWIDTH-1:0]     itr_q, itr_next;
  logic                    row_last, last_write;
  wr_slot_t                push;
  wr_slot_t                dline [PIPESTAGES];

  assign row_last   = (row == ROW_LAST);
  assign row_inc    = row_last ? '0 : row + ROW_ONE;
  // The final row of a layer leaving the delay line marks the end of that layer.
  assign last_write = dline[PIPESTAGES-1].valid && (dline[PIPESTAGES-1].addr == ROW_LAST);

  always_comb begin
    state_next = state;
    row_next   = row;
    layer_next = layer;
    itr_next   = itr_q;
    unique case (state)
      S_IDLE: if (start) begin
        state_next = S_LOAD;
        row_next   = '0;
        layer_next = 1'b0;
        itr_next   = '0;
      end
      S_LOAD: begin
        row_next = row_inc;
        if (row_last) begin
          state_next = S_READ;
          layer_next = 1'b0;
          itr_next   = '0;
        end
      end
      S_READ: begin
        row_next = row_inc;
        if (row_last) state_next = S_WAIT;
      end
      S_WAIT: if (last_write) begin
        state_next = S_READ;
        if (layer != LAYER_LAST) begin
          layer_next = layer + 1'b1;
        end else if (early_stop || itr_q == ITR_LAST) begin
          state_next = S_UNLOAD;
        end else begin
          itr_next   = itr_q + ITR_ONE;
          layer_next = 1'b0;
        end
      end
      S_UNLOAD: begin
        row_next = row_inc;
        if (row_last) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      row   <= '0;
      layer <= 1'b0;
      itr_q <= '0;
    end else begin
      state <= state_next;
      row   <= row_next;
      layer <= layer_next;
      itr_q <= itr_next;
    end
  end

  always_comb begin
    push       = '0;
    push.valid = (state == S_READ);
    if (state == S_READ) begin
      push.addr  = row;
      push.layer = layer;
    end
  end

  // NOTE: unlike a data memory, this delay line must be reset, because reset
  // has to cancel writes that are still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPESTAGES; i++) dline[i] <= '0;
    end else begin
      dline[0] <= push;
      for (int i = 1; i < PIPESTAGES; i++) dline[i] <= dline[i-1];
    end
  end

  assign loaden                   = (state == S_LOAD);
  assign load_addr                = loaden ? row : '0;
  assign rd_en                    = (state == S_READ);
  assign rd_address               = rd_en ? row : '0;
  assign rd_layer                 = rd_en & layer;
  assign wr_en                    = dline[PIPESTAGES-1].valid;
  assign wr_address               = dline[PIPESTAGES-1].addr;
  assign wr_layer                 = dline[PIPESTAGES-1].layer;
  assign firstprocessing_indicate = (itr_q == '0) && (state == S_READ || state == S_WAIT);
  assign unload_en                = (state == S_UNLOAD);
  assign unloadAddress            = unload_en ? row : '0;
  assign itr                      = itr_q;
  assign busy                     = (state != S_IDLE);
  assign done                     = (state == S_DONE);

endmodule

// File: tb/tb_lmem_decode_sequencer.sv
// Directed bench for lmem_decode_sequencer: every output is compared each cycle
// against a cycle-number timeline of the decode.
module tb_lmem_decode_sequencer;

  localparam int AW = 5;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst, start, early_stop;
  logic          loaden, rd_en, rd_layer, wr_en, wr_layer;
  logic          firstprocessing_indicate, unload_en, busy, done;
  logic [AW-1:0] load_addr, rd_address, wr_address, unloadAddress;
  logic [IW-1:0] itr;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  lmem_decode_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .early_stop(early_stop),
    .loaden(loaden), .load_addr(load_addr),
    .rd_en(rd_en), .rd_address(rd_address), .rd_layer(rd_layer),
    .wr_en(wr_en), .wr_address(wr_address), .wr_layer(wr_layer),
    .firstprocessing_indicate(firstprocessing_indicate),
    .unload_en(unload_en), .unloadAddress(unloadAddress),
    .itr(itr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_idle(input int exp_itr);
    check("loaden", 32'(loaden), 0);       check("load_addr", 32'(load_addr), 0);
    check("rd_en", 32'(rd_en), 0);         check("rd_address", 32'(rd_address), 0);
    check("rd_layer", 32'(rd_layer), 0);   check("wr_en", 32'(wr_en), 0);
    check("wr_address", 32'(wr_address), 0); check("wr_layer", 32'(wr_layer), 0);
    check("first", 32'(firstprocessing_indicate), 0);
    check("unload_en", 32'(unload_en), 0); check("unloadAddress", 32'(unloadAddress), 0);
    check("itr", 32'(itr), exp_itr);       check("busy", 32'(busy), 0);
    check("done", 32'(done), 0);
  endtask

  // Cycle c counts from the start pulse; n = iterations run; prev = itr before start.
  task automatic check_timeline(input int c, input int n, input int prev);
    int e_last, rel, ld, la, rd, ra, rl, wr, wa, wl, fp, it, ul, ua, dn, bz;
    e_last = 21 + 70*n - 1;
    ld = (c >= 1 && c <= 20);  la = ld ? c - 1 : 0;
    rd = 0; ra = 0; rl = 0; wr = 0; wa = 0; wl = 0;
    if (c >= 21 && c <= e_last) begin
      rel = c - 21;
      if (rel % 35 < 20) begin rd = 1; ra = rel % 35; rl = (rel % 70) / 35; end
    end
    if (c >= 36 && c <= e_last) begin
      rel = c - 36;
      if (rel % 35 < 20) begin wr = 1; wa = rel % 35; wl = (rel % 70) / 35; end
    end
    fp = (c >= 21 && c <= 90);
    if (c == 0)                      it = prev;
    else if (c <= 20)                it = 0;
    else if (c <= e_last)            it = (c - 21) / 70;
    else                             it = n - 1;
    ul = (c >= e_last + 1 && c <= e_last + 20);  ua = ul ? c - e_last - 1 : 0;
    dn = (c == e_last + 21);
    bz = (c >= 1 && c <= e_last + 21);
    check("loaden", 32'(loaden), ld);        check("load_addr", 32'(load_addr), la);
    check("rd_en", 32'(rd_en), rd);          check("rd_address", 32'(rd_address), ra);
    check("rd_layer", 32'(rd_layer), rl);    check("wr_en", 32'(wr_en), wr);
    check("wr_address", 32'(wr_address), wa); check("wr_layer", 32'(wr_layer), wl);
    check("first", 32'(firstprocessing_indicate), fp);
    check("unload_en", 32'(unload_en), ul);  check("unloadAddress", 32'(unloadAddress), ua);
    check("itr", 32'(itr), it);              check("busy", 32'(busy), bz);
    check("done", 32'(done), dn);
  endtask

  // One decode from a start pulse; es_itr >= 0 holds early_stop through that iteration.
  task automatic run_decode(input int n, input int es_itr, input bit extra, input int prev);
    int e_last;
    e_last = 21 + 70*n - 1;
    for (int c = 0; c <= e_last + 24; c++) begin
      cyc = c;
      start = (c == 0) || (extra && (c == 10 || c == 700 || c == e_last + 21));
      early_stop = (es_itr >= 0) && (c >= 21 + 70*es_itr) && (c <= 21 + 70*es_itr + 69);
      check_timeline(c, n, prev);
      @(negedge clk);
    end
    start = 1'b0;
    early_stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; early_stop = 1'b0;
    repeat (3) @(negedge clk);
    check_idle(0);
    rst = 1'b0;
    @(negedge clk);

    // Full 10-iteration decode, no early stop.
    run_decode(10, -1, 1'b0, 0);
    // early_stop held through iteration 2; itr 9 from the previous run clears on start.
    run_decode(3, 2, 1'b0, 9);
    // Stray start pulses at cycles 10, 700 and in the DONE cycle are ignored.
    run_decode(10, -1, 1'b1, 2);

    // Reset during the layer-0 write phase, then restart.
    for (int c = 0; c <= 45; c++) begin
      cyc = c;
      start = (c == 0);
      rst = (c == 45);
      check_timeline(c, 10, 9);
      @(negedge clk);
    end
    rst = 1'b0;
    for (int c = 46; c <= 50; c++) begin
      cyc = c;
      start = (c == 50);
      check_idle(0);
      @(negedge clk);
    end
    start = 1'b0;
    for (int c = 51; c <= 90; c++) begin
      cyc = c;
      check_timeline(c - 50, 10, 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
